// File: rtl/color_classifier.sv
`default_nettype none
// ============================================================================
// color_classifier: scans six RGB565 reference colours, reports nearest match
// Rev 1.0
// ============================================================================
module color_classifier #(
   parameter logic [7:0] MAX_DIST = 8'd60
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        start,
   input  logic [15:0] rgb_in,
   output logic [1:0]  addr1,
   output logic [1:0]  addr2,
   input  logic [15:0] rom_q,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic [2:0]  color,
   output logic [7:0]  distance
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] C_LAST_IDX = 3'd5;
   localparam logic [2:0] C_UNKNOWN  = 3'd7;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  min_dist_q, min_dist_d;
   logic [2:0]  min_idx_q, min_idx_d;
   logic [15:0] sample_q, sample_d;
   logic [2:0]  color_q, color_d;
   logic [7:0]  distance_q, distance_d;
   logic        valid_q, valid_d;

   logic [7:0]  entry_dist;
   logic [7:0]  cand_dist;
   logic [2:0]  cand_idx;

   function automatic logic [5:0] abs_diff6(input logic [5:0] a, input logic [5:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   // R and B are scaled to 6 bits so all three channels weigh alike
   always_comb begin
      entry_dist = {2'b00, abs_diff6({sample_q[15:11], 1'b0}, {rom_q[15:11], 1'b0})}
                 + {2'b00, abs_diff6(sample_q[10:5], rom_q[10:5])}
                 + {2'b00, abs_diff6({sample_q[4:0], 1'b0}, {rom_q[4:0], 1'b0})};
   end

   // strict compare keeps the lower index on ties
   always_comb begin
      cand_dist = min_dist_q;
      cand_idx  = min_idx_q;
      if (entry_dist < min_dist_q) begin
         cand_dist = entry_dist;
         cand_idx  = idx_q;
      end
   end

   always_comb begin
      addr1 = 2'd0;
      addr2 = 2'd0;
      if (state_q == ST_SCAN) begin
         case (idx_q)
            3'd1:    begin addr1 = 2'd0; addr2 = 2'd1; end
            3'd2:    begin addr1 = 2'd0; addr2 = 2'd2; end
            3'd3:    begin addr1 = 2'd1; addr2 = 2'd0; end
            3'd4:    begin addr1 = 2'd1; addr2 = 2'd1; end
            3'd5:    begin addr1 = 2'd1; addr2 = 2'd2; end
            default: begin addr1 = 2'd0; addr2 = 2'd0; end
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      min_dist_d = min_dist_q;
      min_idx_d  = min_idx_q;
      sample_d   = sample_q;
      color_d    = color_q;
      distance_d = distance_q;
      valid_d    = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sample_d   = rgb_in;
               idx_d      = 3'd0;
               min_dist_d = 8'hFF;
               min_idx_d  = 3'd0;
               state_d    = ST_SCAN;
            end
         end
         ST_SCAN: begin
            min_dist_d = cand_dist;
            min_idx_d  = cand_idx;
            if (idx_q == C_LAST_IDX) begin
               state_d    = ST_DONE;
               distance_d = cand_dist;
               if (cand_dist <= MAX_DIST) begin
                  valid_d = 1'b1;
                  color_d = cand_idx;
               end else begin
                  valid_d = 1'b0;
                  color_d = C_UNKNOWN;
               end
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q    <= ST_IDLE;
         idx_q      <= 3'd0;
         min_dist_q <= 8'hFF;
         min_idx_q  <= 3'd0;
         sample_q   <= 16'h0000;
         color_q    <= C_UNKNOWN;
         distance_q <= 8'd0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         min_dist_q <= min_dist_d;
         min_idx_q  <= min_idx_d;
         sample_q   <= sample_d;
         color_q    <= color_d;
         distance_q <= distance_d;
         valid_q    <= valid_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign valid    = valid_q;
   assign color    = color_q;
   assign distance = distance_q;

endmodule
`default_nettype wire

// File: tb/tb_color_classifier.sv
`default_nettype none
// ============================================================================
// tb_color_classifier: table, random and protocol checks for color_classifier
// Rev 1.0
// ============================================================================
module tb_color_classifier;

   logic        clk;
   logic        clear;
   logic        start;
   logic [15:0] rgb_in;
   logic [1:0]  addr1;
   logic [1:0]  addr2;
   logic [15:0] rom_q;
   logic        busy;
   logic        done;
   logic        valid;
   logic [2:0]  color;
   logic [7:0]  distance;

   logic [15:0] rom [0:5];
   int          n_checks;
   int          n_fail;

   color_classifier #(.MAX_DIST(8'd60)) dut (
      .clk      (clk),
      .clear    (clear),
      .start    (start),
      .rgb_in   (rgb_in),
      .addr1    (addr1),
      .addr2    (addr2),
      .rom_q    (rom_q),
      .busy     (busy),
      .done     (done),
      .valid    (valid),
      .color    (color),
      .distance (distance)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // row-major 2x3 reference ROM; row 2 and column 3 read as zero
   always_comb begin
      rom_q = 16'h0000;
      if (addr1 < 2'd2 && addr2 < 2'd3)
         rom_q = rom[int'(addr1) * 3 + int'(addr2)];
   end

   typedef struct {
      logic [15:0] rgb;
      logic [2:0]  exp_color;
      logic [7:0]  exp_dist;
      logic        exp_valid;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   function automatic void model(input logic [15:0] s, output logic [2:0] c,
                                 output logic [7:0] d, output logic v);
      int best, besti, dd;
      best  = 1000;
      besti = 0;
      for (int i = 0; i < 6; i++) begin
         dd = iabs(2 * int'(s[15:11]) - 2 * int'(rom[i][15:11]))
            + iabs(int'(s[10:5]) - int'(rom[i][10:5]))
            + iabs(2 * int'(s[4:0]) - 2 * int'(rom[i][4:0]));
         if (dd < best) begin
            best  = dd;
            besti = i;
         end
      end
      d = 8'(best);
      v = (best <= 60);
      c = v ? 3'(besti) : 3'd7;
   endfunction

   task automatic init_rom();
      rom[0] = 16'h5E0B;  // white
      rom[1] = 16'h4801;  // red
      rom[2] = 16'hD880;  // orange
      rom[3] = 16'hE400;  // yellow
      rom[4] = 16'h0780;  // green
      rom[5] = 16'h01AF;  // blue
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_color"}, color, 7);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_dist"},  distance, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_addr"},  {addr1, addr2}, 0);
   endtask

   // One classification on the fixed schedule; disturb pokes start/rgb_in mid-scan and in DONE
   task automatic run_case(input string tag, input logic [15:0] rgb, input logic [2:0] ec,
                           input logic [7:0] ed, input logic ev, input bit disturb);
      @(negedge clk);
      rgb_in = rgb;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         chk({tag, "_addr1"}, addr1, k / 3);
         chk({tag, "_addr2"}, addr2, k % 3);
         chk({tag, "_busy"},  busy, 1);
         chk({tag, "_early_done"}, done, 0);
         if (disturb && k == 2) begin
            rgb_in = ~rgb;
            start  = 1'b1;
         end
         if (disturb && k == 4) start = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_done"},  done, 1);
      chk({tag, "_color"}, color, ec);
      chk({tag, "_dist"},  distance, ed);
      chk({tag, "_valid"}, valid, ev);
      chk({tag, "_addr_done"}, {addr1, addr2}, 0);
      if (disturb) start = 1'b1;
      @(negedge clk);
      chk({tag, "_done_clr"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_hold_color"}, color, ec);
      start = 1'b0;
   endtask

   initial begin
      vec_t        vecs [0:4];
      logic [2:0]  mc;
      logic [7:0]  md;
      logic        mv;
      logic [15:0] r;
      int          prev, pulses;
      bit          saw_done;

      n_checks = 0;
      n_fail   = 0;
      init_rom();
      vecs[0] = '{16'h4801, 3'd1, 8'd0,  1'b1};
      vecs[1] = '{16'h4802, 3'd1, 8'd2,  1'b1};
      vecs[2] = '{16'h5E0B, 3'd0, 8'd0,  1'b1};
      vecs[3] = '{16'hFFFF, 3'd7, 8'd95, 1'b0};
      vecs[4] = '{16'h01AF, 3'd5, 8'd0,  1'b1};

      clear  = 1'b0;
      start  = 1'b0;
      rgb_in = 16'h0000;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      clear = 1'b1;
      repeat (5) @(negedge clk);
      chk_reset_vals("reset_idle");

      for (int i = 0; i < 5; i++)
         run_case($sformatf("vec%0d", i), vecs[i].rgb, vecs[i].exp_color,
                  vecs[i].exp_dist, vecs[i].exp_valid, 1'b0);

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 1)
            r = rom[$urandom_range(0, 5)] ^ (16'($urandom) & 16'h18C3);
         else
            r = 16'($urandom);
         model(r, mc, md, mv);
         run_case($sformatf("rand%0d", i), r, mc, md, mv, 1'b0);
      end

      // start held high: one result every 8 cycles
      @(negedge clk);
      rgb_in = 16'h5E0B;
      start  = 1'b1;
      prev   = -1;
      pulses = 0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            chk("held_color", color, 0);
            if (prev < 0) chk("held_first", i, 7);
            else          chk("held_gap", i - prev, 8);
            prev = i;
         end
      end
      start = 1'b0;
      chk("held_count", pulses, 4);
      repeat (2) @(negedge clk);

      run_case("disturb", 16'h4802, 3'd1, 8'd2, 1'b1, 1'b1);

      // asynchronous clear in the third SCAN cycle
      @(negedge clk);
      rgb_in = 16'h5E0B;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      clear = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      clear    = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      chk("midrst_no_done", saw_done, 0);
      chk("midrst_color_hold", color, 7);
      run_case("after_rst", 16'h4801, 3'd1, 8'd0, 1'b1, 1'b0);

      rom[2] = 16'h1234;
      rom[4] = 16'h1234;
      run_case("tie", 16'h1234, 3'd2, 8'd0, 1'b1, 1'b0);
      init_rom();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
